// File: rtl/reg_port_arbiter_pkg.sv
// reg_arb_pkg: shared types and constants for the register-port arbiter
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} arb_state_t;
  typedef enum logic {OWN_HOST, OWN_LOCAL} owner_t;
  localparam int RD_LATENCY_MAX = 4;
  localparam int CNT_W = $clog2(RD_LATENCY_MAX + 1);
endpackage

// File: rtl/reg_port_arbiter_slot.sv
// host_req_slot: 1-entry capture buffer for pulsed host write/read commands
module host_req_slot #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_w_en,
  input  logic [AW-1:0] i_w_addr,
  input  logic [DW-1:0] i_w_data,
  input  logic          i_r_en,
  input  logic [AW-1:0] i_r_addr,
  input  logic          i_pop,
  output logic          o_valid,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_drop
);
  logic          valid_q, valid_d, we_q, we_d, drop_q, drop_d, req, take;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  always_comb begin
    req     = i_w_en | i_r_en;
    take    = req & (~valid_q | i_pop);
    valid_d = take | (valid_q & ~i_pop);
    we_d    = take ? i_w_en : we_q;
    addr_d  = take ? (i_w_en ? i_w_addr : i_r_addr) : addr_q;
    data_d  = take ? i_w_data : data_q;
    // a simultaneous read is discarded in favour of the write
    drop_d  = (req & ~take) | (i_w_en & i_r_en);
  end
  always_ff @(posedge clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end
  assign o_valid = valid_q;
  assign o_we    = we_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_drop  = drop_q;
endmodule

// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: round-robin sharing of a single-port register file between host and local requesters
module reg_port_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4,
  parameter int RD_LATENCY  = 1,
  localparam int DW = WORD_WIDTH * VALUE_WORDS
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_h_w_en,
  input  logic [WORD_WIDTH-1:0] i_h_w_addr,
  input  logic [DW-1:0]         i_h_w_data,
  input  logic                  i_h_r_en,
  input  logic [WORD_WIDTH-1:0] i_h_r_addr,
  output logic [DW-1:0]         o_h_r_data,
  output logic                  o_h_r_dv,
  output logic                  o_h_drop,
  input  logic                  i_l_req,
  input  logic                  i_l_we,
  input  logic [WORD_WIDTH-1:0] i_l_addr,
  input  logic [DW-1:0]         i_l_w_data,
  output logic                  o_l_gnt,
  output logic [DW-1:0]         o_l_r_data,
  output logic                  o_l_r_dv,
  output logic [WORD_WIDTH-1:0] o_rf_addr,
  output logic [DW-1:0]         o_rf_w_data,
  output logic                  o_rf_w_en,
  output logic                  o_rf_r_en,
  input  logic [DW-1:0]         i_rf_r_data
);
  arb_state_t            state_q, state_d;
  owner_t                last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] rf_addr_q, rf_addr_d, s_addr;
  logic [DW-1:0]         rf_w_data_q, rf_w_data_d, h_r_data_q, h_r_data_d, l_r_data_q, l_r_data_d, s_data;
  logic                  rf_w_en_d, rf_w_en_q, rf_r_en_d, rf_r_en_q;
  logic                  h_r_dv_d, h_r_dv_q, l_r_dv_d, l_r_dv_q;
  logic                  s_valid, s_we, s_drop;
  logic                  idle, gnt_h, gnt_l, gnt, gnt_we, done;
  host_req_slot #(.AW(WORD_WIDTH), .DW(DW)) u_slot (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_w_en   (i_h_w_en),
    .i_w_addr (i_h_w_addr),
    .i_w_data (i_h_w_data),
    .i_r_en   (i_h_r_en),
    .i_r_addr (i_h_r_addr),
    .i_pop    (gnt_h),
    .o_valid  (s_valid),
    .o_we     (s_we),
    .o_addr   (s_addr),
    .o_data   (s_data),
    .o_drop   (s_drop)
  );
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      last_q      <= OWN_LOCAL;
      cnt_q       <= '0;
      rf_addr_q   <= '0;
      rf_w_data_q <= '0;
      rf_w_en_q   <= 1'b0;
      rf_r_en_q   <= 1'b0;
      h_r_data_q  <= '0;
      h_r_dv_q    <= 1'b0;
      l_r_data_q  <= '0;
      l_r_dv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rf_addr_q   <= rf_addr_d;
      rf_w_data_q <= rf_w_data_d;
      rf_w_en_q   <= rf_w_en_d;
      rf_r_en_q   <= rf_r_en_d;
      h_r_data_q  <= h_r_data_d;
      h_r_dv_q    <= h_r_dv_d;
      l_r_data_q  <= l_r_data_d;
      l_r_dv_q    <= l_r_dv_d;
    end
  end
  // ties go to whichever side was not granted last; last_q also names the read owner
  always_comb begin
    idle   = (state_q == IDLE) & ~i_reset;
    gnt_h  = idle & s_valid & (~i_l_req | (last_q == OWN_LOCAL));
    gnt_l  = idle & i_l_req & (~s_valid | (last_q == OWN_HOST));
    gnt    = gnt_h | gnt_l;
    gnt_we = gnt_h ? s_we : i_l_we;
    done   = (state_q == RD_WAIT) & (cnt_q == CNT_W'(RD_LATENCY));
  end
  always_comb begin
    state_d = (state_q == IDLE)    ? ((gnt & ~gnt_we) ? RD_WAIT : IDLE) :
              (state_q == RD_WAIT) ? (done ? RD_RESP : RD_WAIT) : IDLE;
  end
  always_comb begin
    last_d      = gnt ? (gnt_h ? OWN_HOST : OWN_LOCAL) : last_q;
    cnt_d       = (state_q == RD_WAIT) ? cnt_q + 1'b1 : '0;
    rf_w_en_d   = gnt & gnt_we;
    rf_r_en_d   = gnt & ~gnt_we;
    rf_addr_d   = gnt ? (gnt_h ? s_addr : i_l_addr) : rf_addr_q;
    rf_w_data_d = rf_w_en_d ? (gnt_h ? s_data : i_l_w_data) : rf_w_data_q;
    h_r_dv_d    = done & (last_q == OWN_HOST);
    l_r_dv_d    = done & (last_q == OWN_LOCAL);
    h_r_data_d  = h_r_dv_d ? i_rf_r_data : h_r_data_q;
    l_r_data_d  = l_r_dv_d ? i_rf_r_data : l_r_data_q;
  end
  assign o_l_gnt     = gnt_l;
  assign o_h_drop    = s_drop;
  assign o_h_r_data  = h_r_data_q;
  assign o_h_r_dv    = h_r_dv_q;
  assign o_l_r_data  = l_r_data_q;
  assign o_l_r_dv    = l_r_dv_q;
  assign o_rf_addr   = rf_addr_q;
  assign o_rf_w_data = rf_w_data_q;
  assign o_rf_w_en   = rf_w_en_q;
  assign o_rf_r_en   = rf_r_en_q;
endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb_reg_port_arbiter: directed scoreboard bench for the register-port arbiter
module tb_reg_port_arbiter;
  localparam int L = 3;
  typedef struct packed {logic we; logic [7:0] addr; logic [31:0] data;} op_t;
  typedef struct packed {logic local_own; logic [31:0] data;} rsp_t;
  logic clk, i_reset, i_h_w_en, i_h_r_en, i_l_req, i_l_we;
  logic [7:0] i_h_w_addr, i_h_r_addr, i_l_addr, o_rf_addr;
  logic [31:0] i_h_w_data, i_l_w_data, o_h_r_data, o_l_r_data, o_rf_w_data, i_rf_r_data;
  logic o_h_r_dv, o_h_drop, o_l_gnt, o_l_r_dv, o_rf_w_en, o_rf_r_en;
  logic [31:0] mem [256];
  logic [31:0] pipe [L];
  op_t op_q[$];
  rsp_t rsp_q[$];
  int tests = 0, fails = 0;
  reg_port_arbiter #(.WORD_WIDTH(8), .VALUE_WORDS(4), .RD_LATENCY(L)) dut (
    .clk(clk), .i_reset(i_reset),
    .i_h_w_en(i_h_w_en), .i_h_w_addr(i_h_w_addr), .i_h_w_data(i_h_w_data),
    .i_h_r_en(i_h_r_en), .i_h_r_addr(i_h_r_addr),
    .o_h_r_data(o_h_r_data), .o_h_r_dv(o_h_r_dv), .o_h_drop(o_h_drop),
    .i_l_req(i_l_req), .i_l_we(i_l_we), .i_l_addr(i_l_addr), .i_l_w_data(i_l_w_data),
    .o_l_gnt(o_l_gnt), .o_l_r_data(o_l_r_data), .o_l_r_dv(o_l_r_dv),
    .o_rf_addr(o_rf_addr), .o_rf_w_data(o_rf_w_data), .o_rf_w_en(o_rf_w_en),
    .o_rf_r_en(o_rf_r_en), .i_rf_r_data(i_rf_r_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // register file model: data appears L cycles after the read strobe cycle
  always @(posedge clk) begin
    if (o_rf_w_en) mem[o_rf_addr] <= o_rf_w_data;
    pipe[0] <= o_rf_r_en ? mem[o_rf_addr] : 32'h0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign i_rf_r_data = pipe[L-1];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_op(input logic we, input logic [7:0] a, input logic [31:0] d);
    op_q.push_back('{we: we, addr: a, data: d});
  endtask
  task automatic push_rsp(input logic loc, input logic [31:0] d);
    rsp_q.push_back('{local_own: loc, data: d});
  endtask
  always @(negedge clk) begin
    op_t e;
    rsp_t r;
    if (o_rf_w_en || o_rf_r_en) begin
      if (op_q.size() == 0) chk("op_unexp", {o_rf_w_en, o_rf_r_en}, 2'b00);
      else begin
        e = op_q.pop_front();
        chk("rf_op", {o_rf_w_en, o_rf_r_en, o_rf_addr, o_rf_w_en ? o_rf_w_data : 32'h0},
            {e.we, ~e.we, e.addr, e.we ? e.data : 32'h0});
      end
    end
    if (o_h_r_dv || o_l_r_dv) begin
      if (rsp_q.size() == 0) chk("rsp_unexp", {o_h_r_dv, o_l_r_dv}, 2'b00);
      else begin
        r = rsp_q.pop_front();
        chk("rsp", {o_h_r_dv, o_l_r_dv, o_l_r_dv ? o_l_r_data : o_h_r_data},
            {~r.local_own, r.local_own, r.data});
      end
    end
  end
  initial begin
    {i_h_w_en, i_h_r_en, i_l_we} = '0;
    {i_h_w_addr, i_h_r_addr, i_l_addr, i_h_w_data, i_l_w_data} = '0;
    i_reset = 1'b1;
    i_l_req = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_outs", {o_h_r_data, o_h_r_dv, o_h_drop, o_l_gnt, o_l_r_data, o_l_r_dv,
                     o_rf_addr, o_rf_w_data, o_rf_w_en, o_rf_r_en}, '0);
    i_l_req = 1'b0;
    i_reset = 1'b0;
    tick();
    // back-to-back host writes
    i_h_w_en = 1'b1; i_h_w_addr = 8'h05; i_h_w_data = 32'h1122_3344;
    push_op(1'b1, 8'h05, 32'h1122_3344);
    tick();
    i_h_w_addr = 8'h07; i_h_w_data = 32'hDEAD_BEEF;
    push_op(1'b1, 8'h07, 32'hDEAD_BEEF);
    @(negedge clk); chk("w1_early", o_rf_w_en, 1'b0);
    tick();
    i_h_w_en = 1'b0;
    @(negedge clk); chk("w1_en", {o_rf_w_en, o_rf_addr}, {1'b1, 8'h05});
    chk("w1_nodrop", o_h_drop, 1'b0);
    tick();
    @(negedge clk); chk("w2_en", {o_rf_w_en, o_rf_addr}, {1'b1, 8'h07});
    chk("w_no_dv", {o_h_r_dv, o_l_r_dv, o_h_drop}, 3'b000);
    tick();
    // local read of 0x07
    i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 8'h07;
    push_op(1'b0, 8'h07, 32'h0); push_rsp(1'b1, 32'hDEAD_BEEF);
    @(negedge clk); chk("l_gnt", o_l_gnt, 1'b1);
    tick();
    i_l_req = 1'b0;
    @(negedge clk); chk("l_rd_en", {o_rf_r_en, o_rf_addr}, {1'b1, 8'h07});
    repeat (L) tick();
    @(negedge clk); chk("l_dv_early", o_l_r_dv, 1'b0);
    tick();
    @(negedge clk); chk("l_dv", {o_l_r_dv, o_h_r_dv, o_l_r_data}, {2'b10, 32'hDEAD_BEEF});
    tick();
    // round robin with both sides contending
    i_h_w_en = 1'b1; i_h_w_addr = 8'h10; i_h_w_data = 32'hA1A1_A1A1;
    push_op(1'b1, 8'h10, 32'hA1A1_A1A1);
    @(negedge clk); chk("rr_gnt0", o_l_gnt, 1'b0);
    tick();
    i_h_w_addr = 8'h11; i_h_w_data = 32'hA2A2_A2A2;
    i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 8'h20; i_l_w_data = 32'hB1B1_B1B1;
    push_op(1'b1, 8'h20, 32'hB1B1_B1B1); push_op(1'b1, 8'h11, 32'hA2A2_A2A2);
    @(negedge clk); chk("rr_gnt1", o_l_gnt, 1'b0);
    tick();
    i_h_w_en = 1'b0;
    @(negedge clk); chk("rr_gnt2", o_l_gnt, 1'b1);
    chk("rr_nodrop", o_h_drop, 1'b0);
    tick();
    i_l_addr = 8'h21; i_l_w_data = 32'hB2B2_B2B2;
    push_op(1'b1, 8'h21, 32'hB2B2_B2B2);
    @(negedge clk); chk("rr_gnt3", o_l_gnt, 1'b0);
    tick();
    @(negedge clk); chk("rr_gnt4", o_l_gnt, 1'b1);
    tick();
    i_l_req = 1'b0;
    tick();
    // host pulses during a local read; second one overflows the slot
    i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 8'h20;
    push_op(1'b0, 8'h20, 32'h0); push_rsp(1'b1, 32'hB1B1_B1B1);
    @(negedge clk); chk("t4_gnt", o_l_gnt, 1'b1);
    tick();
    i_l_req = 1'b0;
    i_h_w_en = 1'b1; i_h_w_addr = 8'h40; i_h_w_data = 32'hC1C1_C1C1;
    push_op(1'b1, 8'h40, 32'hC1C1_C1C1);
    tick();
    i_h_w_addr = 8'h41; i_h_w_data = 32'hC2C2_C2C2;
    i_l_req = 1'b1; i_l_we = 1'b1; i_l_addr = 8'h42; i_l_w_data = 32'hD1D1_D1D1;
    push_op(1'b1, 8'h42, 32'hD1D1_D1D1);
    @(negedge clk); chk("t4_gnt_busy", {o_l_gnt, o_h_drop}, 2'b00);
    tick();
    i_h_w_en = 1'b0;
    @(negedge clk); chk("t4_drop", o_h_drop, 1'b1);
    tick();
    @(negedge clk); chk("t4_drop_1cyc", {o_h_drop, o_l_gnt}, 2'b00);
    tick();
    @(negedge clk); chk("t4_dv", {o_l_r_dv, o_l_gnt, o_l_r_data}, {2'b10, 32'hB1B1_B1B1});
    tick();
    @(negedge clk); chk("t4_host_first", o_l_gnt, 1'b0);
    tick();
    @(negedge clk); chk("t4_local_next", o_l_gnt, 1'b1);
    tick();
    i_l_req = 1'b0;
    tick();
    // write and read pulsed together
    i_h_w_en = 1'b1; i_h_w_addr = 8'h50; i_h_w_data = 32'hE1E1_E1E1;
    i_h_r_en = 1'b1; i_h_r_addr = 8'h51;
    push_op(1'b1, 8'h50, 32'hE1E1_E1E1);
    tick();
    i_h_w_en = 1'b0; i_h_r_en = 1'b0;
    @(negedge clk); chk("t5_drop", o_h_drop, 1'b1);
    tick();
    @(negedge clk); chk("t5_wr", {o_rf_w_en, o_rf_r_en, o_rf_addr}, {2'b10, 8'h50});
    tick();
    // host read of 0x10
    i_h_r_en = 1'b1; i_h_r_addr = 8'h10;
    push_op(1'b0, 8'h10, 32'h0); push_rsp(1'b0, 32'hA1A1_A1A1);
    tick();
    i_h_r_en = 1'b0;
    repeat (L + 2) tick();
    @(negedge clk); chk("h_dv", {o_h_r_dv, o_l_r_dv, o_h_r_data}, {2'b10, 32'hA1A1_A1A1});
    chk("l_hold", o_l_r_data, 32'hB1B1_B1B1);
    tick();
    // reset while a read is outstanding
    i_l_req = 1'b1; i_l_we = 1'b0; i_l_addr = 8'h07;
    push_op(1'b0, 8'h07, 32'h0);
    tick();
    i_l_req = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    @(negedge clk);
    chk("t6_rst", {o_h_r_data, o_h_r_dv, o_h_drop, o_l_gnt, o_l_r_data, o_l_r_dv,
                   o_rf_addr, o_rf_w_data, o_rf_w_en, o_rf_r_en}, '0);
    repeat (L + 3) tick();
    i_l_req = 1'b1; i_l_addr = 8'h05;
    push_op(1'b0, 8'h05, 32'h0); push_rsp(1'b1, 32'h1122_3344);
    @(negedge clk); chk("t6_gnt", o_l_gnt, 1'b1);
    tick();
    i_l_req = 1'b0;
    repeat (L + 1) tick();
    @(negedge clk); chk("t6_dv", {o_l_r_dv, o_l_r_data}, {1'b1, 32'h1122_3344});
    repeat (3) tick();
    chk("ops_left", op_q.size(), 0);
    chk("rsp_left", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
